// File: rtl/regfile_read_stage_np.sv
// regfile_read_stage_np: GPR read stage with write-back bypass, operand muxing, busy scoreboard and per-lane RAW hazard flags
module regfile_read_stage_np #(
  parameter int LANES = 2,
  parameter int WPORTS = 2,
  parameter int DATA_W = 32,
  parameter int NREG = 32,
  parameter int AW = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [WPORTS-1:0]        wr_en,
  input  logic [WPORTS*AW-1:0]     wr_addr,
  input  logic [WPORTS*DATA_W-1:0] wr_data,
  input  logic [LANES-1:0]         in_valid,
  input  logic [LANES*AW-1:0]      in_rj,
  input  logic [LANES*AW-1:0]      in_rk,
  input  logic [LANES*AW-1:0]      in_rd,
  input  logic [LANES-1:0]         in_rd_we,
  input  logic [LANES*2-1:0]       in_src1_sel,
  input  logic [LANES*2-1:0]       in_src2_sel,
  input  logic [LANES*32-1:0]      in_pc,
  input  logic [LANES*DATA_W-1:0]  in_imm,
  input  logic [63:0]              stable_counter,
  output logic [LANES-1:0]         raw_hazard,
  output logic [LANES-1:0]         out_valid,
  output logic [LANES*AW-1:0]      out_rd,
  output logic [LANES-1:0]         out_rd_we,
  output logic [LANES*32-1:0]      out_pc,
  output logic [LANES*DATA_W-1:0]  out_src1,
  output logic [LANES*DATA_W-1:0]  out_src2
);
  logic [DATA_W-1:0] rf_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [LANES-1:0] valid_q, rd_we_q;
  logic [LANES*AW-1:0] rd_q;
  logic [LANES*32-1:0] pc_q;
  logic [LANES*DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
  logic adv;
  assign adv = !stall && !flush;
  function automatic logic wr_hit(input logic [AW-1:0] a);
    wr_hit = 1'b0;
    for (int p = 0; p < WPORTS; p++) wr_hit |= wr_en[p] && wr_addr[p*AW +: AW] == a;
  endfunction
  function automatic logic [DATA_W-1:0] rf_rd(input logic [AW-1:0] a);
    rf_rd = rf_q[a];
    for (int p = 0; p < WPORTS; p++)
      if (wr_en[p] && wr_addr[p*AW +: AW] == a) rf_rd = wr_data[p*DATA_W +: DATA_W];
    if (a == '0) rf_rd = '0;
  endfunction
  function automatic logic src_haz(input logic [AW-1:0] s, input int l);
    src_haz = busy_q[s] && !wr_hit(s);
    for (int i = 0; i < LANES; i++)
      src_haz |= i < l && in_valid[i] && in_rd_we[i] && in_rd[i*AW +: AW] == s;
    src_haz &= s != '0;
  endfunction
  always_comb begin
    src1_d = '0;
    src2_d = '0;
    raw_hazard = '0;
    for (int l = 0; l < LANES; l++) begin
      src1_d[l*DATA_W +: DATA_W] = in_src1_sel[2*l +: 2] == 2'd0 ? rf_rd(in_rj[l*AW +: AW]) :
                                   in_src1_sel[2*l +: 2] == 2'd1 ? DATA_W'(in_pc[l*32 +: 32]) : '0;
      src2_d[l*DATA_W +: DATA_W] = in_src2_sel[2*l +: 2] == 2'd0 ? rf_rd(in_rk[l*AW +: AW]) :
                                   in_src2_sel[2*l +: 2] == 2'd1 ? in_imm[l*DATA_W +: DATA_W] :
                                   in_src2_sel[2*l +: 2] == 2'd2 ? DATA_W'(stable_counter[31:0]) :
                                   DATA_W'(stable_counter[63:32]);
      raw_hazard[l] = in_valid[l] &&
                      ((in_src1_sel[2*l +: 2] == 2'd0 && src_haz(in_rj[l*AW +: AW], l)) ||
                       (in_src2_sel[2*l +: 2] == 2'd0 && src_haz(in_rk[l*AW +: AW], l)));
    end
  end
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < WPORTS; p++) if (wr_en[p]) busy_d[wr_addr[p*AW +: AW]] = 1'b0;
    for (int l = 0; l < LANES; l++)
      if (adv && in_valid[l] && in_rd_we[l]) busy_d[in_rd[l*AW +: AW]] = 1'b1;
    busy_d[0] = 1'b0;
    if (flush) busy_d = '0;
  end
  always_ff @(posedge clk) begin
    for (int p = 0; p < WPORTS; p++)
      if (wr_en[p] && wr_addr[p*AW +: AW] != '0) rf_q[wr_addr[p*AW +: AW]] <= wr_data[p*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk) busy_q <= !rstn ? '0 : busy_d;
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      valid_q <= '0;
      rd_q <= '0;
      rd_we_q <= '0;
      pc_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
    end else if (!stall) begin
      valid_q <= in_valid;
      rd_q <= in_rd;
      rd_we_q <= in_rd_we;
      pc_q <= in_pc;
      src1_q <= src1_d;
      src2_q <= src2_d;
    end
  end
  assign out_valid = valid_q;
  assign out_rd = rd_q;
  assign out_rd_we = rd_we_q;
  assign out_pc = pc_q;
  assign out_src1 = src1_q;
  assign out_src2 = src2_q;
endmodule
